writeback_cycle: RTL and testbench

Writeback stage of the pipelined processor: consumes the M/W pipeline bundle produced by the memory stage, selects the result (ALU, load data or PC+4), and retires it through the register-file write port. A 2-entry retire buffer absorbs register-file backpressure and stalls the memory stage via StallW when full. It also exports a pending-destination mask for the hazard unit and an optional retire counter.

---
 rtl/procesador_pkg.sv | 38 +++
 rtl/wb_retire_fifo.sv | 80 ++++++++
 rtl/writeback_cycle.sv | 124 ++++++++++++
 tb/tb_writeback_cycle.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/procesador_pkg.sv
// Shared types and constants for the processor pipeline.
// Used by the writeback stage and its retire buffer.
package procesador_pkg;

    localparam int DATA_W   = 34;
    localparam int PC_W     = 34;
    localparam int REG_AW   = 5;
    localparam int WB_DEPTH = 2;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } res_sel_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Jump (link value) wins over the load/ALU choice.
    function automatic res_sel_e res_sel(
        input logic jump,
        input logic src
    );
        res_sel_e s;
        if (jump) begin
            s = RES_PC4;
        end else if (src) begin
            s = RES_MEM;
        end else begin
            s = RES_ALU;
        end
        return s;
    endfunction

endpackage

// File: rtl/wb_retire_fifo.sv
// Two-entry retire buffer between writeback and the register file.
// Entries and their valid bits are exported for hazard tracking.
module wb_retire_fifo
    import procesador_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  wb_entry_t       din_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output wb_entry_t       head_o,
    output wb_entry_t       entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    logic      head_q, head_d;
    logic      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[head_q];

    // Pointer, count and storage updates; a push is refused while full.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        if (do_push) begin
            mem_d[tail_q] = din_i;
            tail_d        = ~tail_q;
        end
        if (do_pop) begin
            head_d = ~head_q;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Entry i holds live data when both are full or it is the lone head.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[i];
            valid_o[i]   = (count_q == 2'd2) ||
                           ((count_q == 2'd1) && (head_q == 1'(i)));
        end
    end

    // Buffer state; reset drops anything still queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            mem_q   <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/writeback_cycle.sv
// Writeback stage: result select, write filter, RF write port, retire count.
// Define WB_RETIRE_CNT_EN to build the 16-bit retired-write counter.
module writeback_cycle
    import procesador_pkg::*;
#(
    parameter int DATA_W = procesador_pkg::DATA_W,
    parameter int PC_W   = procesador_pkg::PC_W,
    parameter int REG_AW = procesador_pkg::REG_AW,
    parameter int DEPTH  = procesador_pkg::WB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ValidW,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcW,
    input  logic                 JumpW,
    input  logic [REG_AW-1:0]    RD_W,
    input  logic [DATA_W-1:0]    ALU_ResultW,
    input  logic [DATA_W-1:0]    ReadDataW,
    input  logic [PC_W-1:0]      PCPlus4W,
    output logic                 StallW,
    output logic                 RF_WE,
    output logic [REG_AW-1:0]    RF_WA,
    output logic [DATA_W-1:0]    RF_WD,
    input  logic                 RF_Ready,
    output logic [2**REG_AW-1:0] PendingMask,
    output logic [15:0]          RetireCnt
);

    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    res_sel_e    sel;
    logic [DATA_W-1:0] result;
    wb_entry_t   new_entry;
    wb_entry_t   head;
    wb_entry_t   entries [DEPTH];
    logic [DEPTH-1:0] valid;

    // Only registered state feeds StallW, so no input reaches it.
    assign StallW = full;
    assign accept = ValidW && !StallW;
    assign push   = accept && RegWriteW && (RD_W != '0);
    assign pop    = RF_WE && RF_Ready;

    // Pick the value the instruction retires.
    always_comb begin
        sel    = res_sel(JumpW, ResultSrcW);
        result = '0;
        unique case (sel)
            RES_ALU: result = ALU_ResultW;
            RES_MEM: result = ReadDataW;
            RES_PC4: result = DATA_W'(PCPlus4W);
            default: result = '0;
        endcase
        new_entry.rd   = RD_W;
        new_entry.data = result;
    end

    wb_retire_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .din_i     (new_entry),
        .pop_i     (pop),
        .full_o    (full),
        .empty_o   (empty),
        .head_o    (head),
        .entries_o (entries),
        .valid_o   (valid)
    );

    // Head of the buffer drives the RF port; idle port reads as zero.
    always_comb begin
        RF_WE = !empty;
        RF_WA = '0;
        RF_WD = '0;
        if (!empty) begin
            RF_WA = head.rd;
            RF_WD = head.data;
        end
    end

    // Destinations still waiting to retire, for the hazard unit.
    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                PendingMask[entries[i].rd] = 1'b1;
            end
        end
        PendingMask[0] = 1'b0;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count each completed register-file write, wrapping at 16 bits.
    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign RetireCnt = cnt_q;
`else
    assign RetireCnt = 16'd0;
`endif

endmodule

// File: tb/tb_writeback_cycle.sv
// Scoreboard bench for writeback_cycle.
// Define WB_RETIRE_CNT_EN to also exercise the counter wrap.
module tb_writeback_cycle;

    logic        clk;
    logic        rst;
    logic        ValidW;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic        JumpW;
    logic [4:0]  RD_W;
    logic [33:0] ALU_ResultW;
    logic [33:0] ReadDataW;
    logic [33:0] PCPlus4W;
    logic        StallW;
    logic        RF_WE;
    logic [4:0]  RF_WA;
    logic [33:0] RF_WD;
    logic        RF_Ready;
    logic [31:0] PendingMask;
    logic [15:0] RetireCnt;

    typedef struct {
        logic [4:0]  rd;
        logic [33:0] data;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    writeback_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .ValidW      (ValidW),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .JumpW       (JumpW),
        .RD_W        (RD_W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .StallW      (StallW),
        .RF_WE       (RF_WE),
        .RF_WA       (RF_WA),
        .RF_WD       (RF_WD),
        .RF_Ready    (RF_Ready),
        .PendingMask (PendingMask),
        .RetireCnt   (RetireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef WB_RETIRE_CNT_EN
        return 16'(n);
`else
        return 16'(n & 0);
`endif
    endfunction

    // Monitor: every completed RF write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && RF_WE && RF_Ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: wa=%0d wd=%0h, expected none",
                         RF_WA, RF_WD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (RF_WA !== e.rd || RF_WD !== e.data) begin
                    n_fail++;
                    $display("FAIL rf_write: wa=%0d wd=%0h, expected wa=%0d wd=%0h",
                             RF_WA, RF_WD, e.rd, e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        idle(1);
        rst = 1'b0;
    endtask

    // Present one bundle, wait out any stall, and record the expected write.
    task automatic send(input logic wr, input logic src, input logic jmp,
                        input logic [4:0] rd, input logic [33:0] alu,
                        input logic [33:0] rdt, input logic [33:0] pc4,
                        input logic [33:0] want);
        int   guard;
        exp_t e;
        guard       = 0;
        ValidW      = 1'b1;
        RegWriteW   = wr;
        ResultSrcW  = src;
        JumpW       = jmp;
        RD_W        = rd;
        ALU_ResultW = alu;
        ReadDataW   = rdt;
        PCPlus4W    = pc4;
        while (StallW && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (StallW) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: stall=%0d, expected 0", StallW);
        end else if (wr && rd != 5'd0) begin
            e.rd   = rd;
            e.data = want;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ValidW = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ValidW = 1'b0;
        RegWriteW = 1'b0;
        ResultSrcW = 1'b0;
        JumpW = 1'b0;
        RD_W = '0;
        ALU_ResultW = '0;
        ReadDataW = '0;
        PCPlus4W = '0;
        RF_Ready = 1'b0;
        idle(2);
        check("rst_we", 64'(RF_WE), 64'd0);
        check("rst_wa", 64'(RF_WA), 64'd0);
        check("rst_wd", 64'(RF_WD), 64'd0);
        check("rst_stall", 64'(StallW), 64'd0);
        check("rst_mask", 64'(PendingMask), 64'd0);
        check("rst_cnt", 64'(RetireCnt), 64'd0);
        rst = 1'b0;
        idle(1);

        // Result-select priority.
        RF_Ready = 1'b1;
        send(1, 1, 0, 5'd3, 34'h5, 34'hA, 34'h10, 34'hA);
        send(1, 1, 1, 5'd3, 34'h5, 34'hA, 34'h10, 34'h10);
        send(1, 0, 0, 5'd3, 34'h5, 34'hA, 34'h10, 34'h5);
        send(1, 0, 1, 5'd7, 34'h5, 34'hA, 34'h3_0000_0001, 34'h3_0000_0001);
        idle(3);
        check("mux_drained", 64'(exp_q.size()), 64'd0);
        check("mux_cnt", 64'(RetireCnt), 64'(exp_cnt(4)));

        // Filtered bundles never reach the register file.
        do_reset();
        RF_Ready = 1'b1;
        send(0, 0, 0, 5'd4, 34'h44, 34'h0, 34'h0, 34'h44);
        send(1, 0, 0, 5'd0, 34'h55, 34'h0, 34'h0, 34'h55);
        check("filt_we", 64'(RF_WE), 64'd0);
        check("filt_mask", 64'(PendingMask), 64'd0);
        idle(3);
        check("filt_cnt", 64'(RetireCnt), 64'd0);

        // Backpressure fills the buffer and stalls.
        do_reset();
        RF_Ready = 1'b0;
        send(1, 0, 0, 5'd1, 34'h11, 34'h0, 34'h0, 34'h11);
        check("bp_stall_one", 64'(StallW), 64'd0);
        send(1, 0, 0, 5'd2, 34'h22, 34'h0, 34'h0, 34'h22);
        check("bp_stall", 64'(StallW), 64'd1);
        check("bp_mask", 64'(PendingMask), 64'h6);
        idle(2);
        check("bp_hold_wa", 64'(RF_WA), 64'd1);
        check("bp_hold_wd", 64'(RF_WD), 64'h11);
        RF_Ready = 1'b1;
        idle(1);
        check("bp_unstall", 64'(StallW), 64'd0);
        check("bp_mask_one", 64'(PendingMask), 64'h4);
        idle(1);
        check("bp_cnt", 64'(RetireCnt), 64'(exp_cnt(2)));
        check("bp_mask_empty", 64'(PendingMask), 64'd0);

        // Asynchronous reset with two writes buffered.
        RF_Ready = 1'b0;
        send(1, 0, 0, 5'd9, 34'h99, 34'h0, 34'h0, 34'h99);
        send(1, 0, 0, 5'd10, 34'hAA, 34'h0, 34'h0, 34'hAA);
        check("mr_stall_pre", 64'(StallW), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mr_we", 64'(RF_WE), 64'd0);
        check("mr_stall", 64'(StallW), 64'd0);
        check("mr_mask", 64'(PendingMask), 64'd0);
        check("mr_cnt", 64'(RetireCnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        RF_Ready = 1'b1;
        idle(4);
        check("mr_no_write", 64'(RF_WE), 64'd0);

        // Same destination twice keeps program order.
        do_reset();
        RF_Ready = 1'b0;
        send(1, 0, 0, 5'd5, 34'h1, 34'h0, 34'h0, 34'h1);
        send(1, 1, 0, 5'd5, 34'h0, 34'h2, 34'h0, 34'h2);
        check("dup_mask", 64'(PendingMask), 64'h20);
        RF_Ready = 1'b1;
        idle(3);
        check("dup_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back stream at full rate.
        do_reset();
        RF_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [33:0] v;
            v = 34'h1000 + 34'(i * 3);
            send(1, 0, 0, 5'(i + 11), v, 34'h0, 34'h0, v);
            check("st_stall", 64'(StallW), 64'd0);
            check("st_lat_we", 64'(RF_WE), 64'd1);
            check("st_lat_wa", 64'(RF_WA), 64'(i + 11));
            check("st_lat_wd", 64'(RF_WD), 64'(v));
        end
        idle(2);
        check("st_cnt", 64'(RetireCnt), 64'(exp_cnt(8)));
        check("st_drained", 64'(exp_q.size()), 64'd0);

`ifdef WB_RETIRE_CNT_EN
        // Counter wraps after 65536 retires.
        do_reset();
        RF_Ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            send(1, 0, 0, 5'((i % 31) + 1), 34'(i), 34'h0, 34'h0, 34'(i));
        end
        idle(2);
        check("wrap_max", 64'(RetireCnt), 64'hFFFF);
        send(1, 0, 0, 5'd1, 34'h7, 34'h0, 34'h0, 34'h7);
        idle(2);
        check("wrap_zero", 64'(RetireCnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
